// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze/acknowledge sequencer for the VGA clock alarm box and buzzer.
// The blink phase advances on frame ticks so the box flashes in step with the display.
module alarm_ring_ctrl #(
  parameter int FRAMES_PER_HALF = 30,
  parameter int RING_HALVES     = 120,
  parameter int SNOOZE_FRAMES   = 18000
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic alarm_match,
  input  logic alarm_enable,
  input  logic ack,
  input  logic snooze,
  output logic box_visible,
  output logic buzzer,
  output logic ringing,
  output logic snoozed
);

  localparam int FMAX = (FRAMES_PER_HALF > SNOOZE_FRAMES) ? FRAMES_PER_HALF : SNOOZE_FRAMES;
  localparam int FW   = ($clog2(FMAX) > 0) ? $clog2(FMAX) : 1;
  localparam int HW   = ($clog2(RING_HALVES) > 0) ? $clog2(RING_HALVES) : 1;

  localparam logic [FW-1:0] HALF_LAST   = FW'(FRAMES_PER_HALF - 1);
  localparam logic [FW-1:0] SNOOZE_LAST = FW'(SNOOZE_FRAMES - 1);
  localparam logic [HW-1:0] RING_LAST   = HW'(RING_HALVES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RING       = 2'd1,
    SNOOZE     = 2'd2,
    WAIT_CLEAR = 2'd3
  } state_t;

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [HW-1:0] half_cnt;
  logic          blink_phase;

  logic half_roll;
  assign half_roll = frame_tick && (frame_cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      half_cnt    <= '0;
      blink_phase <= 1'b0;
      box_visible <= 1'b0;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      snoozed     <= 1'b0;
    end else if (!alarm_enable) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      half_cnt    <= '0;
      blink_phase <= 1'b0;
      box_visible <= 1'b0;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      snoozed     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (alarm_match) begin
            state       <= RING;
            frame_cnt   <= '0;
            half_cnt    <= '0;
            blink_phase <= 1'b1;
            box_visible <= 1'b1;
            buzzer      <= 1'b1;
            ringing     <= 1'b1;
          end
        end

        RING: begin
          if (ack || (half_roll && half_cnt == RING_LAST)) begin
            state       <= WAIT_CLEAR;
            frame_cnt   <= '0;
            half_cnt    <= '0;
            blink_phase <= 1'b0;
            box_visible <= 1'b0;
            buzzer      <= 1'b0;
            ringing     <= 1'b0;
          end else if (snooze) begin
            // A tick landing here is swallowed by the snooze timer reset.
            state       <= SNOOZE;
            frame_cnt   <= '0;
            half_cnt    <= '0;
            blink_phase <= 1'b0;
            box_visible <= 1'b0;
            buzzer      <= 1'b0;
            ringing     <= 1'b0;
            snoozed     <= 1'b1;
          end else if (half_roll) begin
            frame_cnt   <= '0;
            half_cnt    <= half_cnt + HW'(1);
            blink_phase <= ~blink_phase;
            box_visible <= ~blink_phase;
            buzzer      <= ~blink_phase;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end

        SNOOZE: begin
          if (ack) begin
            state     <= WAIT_CLEAR;
            frame_cnt <= '0;
            snoozed   <= 1'b0;
          end else if (frame_tick && frame_cnt == SNOOZE_LAST) begin
            state       <= RING;
            frame_cnt   <= '0;
            half_cnt    <= '0;
            blink_phase <= 1'b1;
            box_visible <= 1'b1;
            buzzer      <= 1'b1;
            ringing     <= 1'b1;
            snoozed     <= 1'b0;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end

        WAIT_CLEAR: begin
          // Hold off until the matching minute passes so it cannot retrigger.
          if (!alarm_match) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Randomized bench for alarm_ring_ctrl against a tick-counting reference model.
module tb_alarm_ring_ctrl;

  localparam int FPH = 3;
  localparam int RH  = 4;
  localparam int SF  = 5;

  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2, M_WAIT = 3;

  logic clk = 1'b0;
  logic reset, frame_tick, alarm_match, alarm_enable, ack, snooze;
  logic box_visible, buzzer, ringing, snoozed;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: burst progress counted in ticks, blink derived arithmetically.
  int mode    = M_IDLE;
  int ring_tk = 0;
  int snz_tk  = 0;

  always #5 clk = ~clk;

  alarm_ring_ctrl #(
    .FRAMES_PER_HALF(FPH),
    .RING_HALVES    (RH),
    .SNOOZE_FRAMES  (SF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .alarm_match (alarm_match),
    .alarm_enable(alarm_enable),
    .ack         (ack),
    .snooze      (snooze),
    .box_visible (box_visible),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozed     (snoozed)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_step(input logic r, input logic e, input logic m,
                                     input logic a, input logic s, input logic t);
    if (r || !e) begin
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE: if (m) begin mode = M_RING; ring_tk = 0; end
        M_RING: begin
          if (a) mode = M_WAIT;
          else if (t && ring_tk + 1 == RH * FPH) mode = M_WAIT;
          else if (s) begin mode = M_SNZ; snz_tk = 0; end
          else if (t) ring_tk++;
        end
        M_SNZ: begin
          if (a) mode = M_WAIT;
          else if (t) begin
            if (snz_tk + 1 == SF) begin mode = M_RING; ring_tk = 0; end
            else snz_tk++;
          end
        end
        default: if (!m) mode = M_IDLE;
      endcase
    end
  endfunction

  task automatic step(input logic r, input logic e, input logic m,
                      input logic a, input logic s, input logic t);
    logic exp_ring, exp_box;
    @(negedge clk);
    reset = r; alarm_enable = e; alarm_match = m; ack = a; snooze = s; frame_tick = t;
    @(posedge clk);
    model_step(r, e, m, a, s, t);
    cyc++;
    #1;
    exp_ring = (mode == M_RING);
    exp_box  = exp_ring && ((ring_tk / FPH) % 2 == 0);
    chk("ringing", ringing, exp_ring);
    chk("box_visible", box_visible, exp_box);
    chk("buzzer", buzzer, exp_box);
    chk("snoozed", snoozed, mode == M_SNZ);
  endtask

  function automatic logic tk();
    return (cyc % 10) == 9;
  endfunction

  task automatic run(input int n, input logic e, input logic m);
    for (int i = 0; i < n; i++) step(1'b0, e, m, 1'b0, 1'b0, tk());
  endtask

  initial begin
    reset = 1'b1; alarm_enable = 1'b1; alarm_match = 1'b1;
    ack = 1'b0; snooze = 1'b0; frame_tick = 1'b0;

    // Reset held with the alarm armed and matching.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tk());
      chk("rst_ringing", ringing, 1'b0);
      chk("rst_box", box_visible, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, tk());
    chk("first_ring", ringing, 1'b1);
    chk("first_box", box_visible, 1'b1);

    // Full unattended burst, then wait-clear behaviour.
    run(150, 1'b1, 1'b1);
    chk("timeout_done", ringing, 1'b0);
    run(8, 1'b1, 1'b0);
    run(3, 1'b1, 1'b1);

    // Ack after a few ticks.
    run(40, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, tk());
    chk("ack_stops", ringing, 1'b0);
    run(5, 1'b1, 1'b1);
    run(5, 1'b1, 1'b0);
    run(20, 1'b1, 1'b1);

    // Snooze then full restart burst.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, tk());
    chk("snz_enter", snoozed, 1'b1);
    run(200, 1'b1, 1'b1);

    // ack and snooze together.
    run(4, 1'b1, 1'b0);
    run(15, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, tk());
    chk("ack_snz_same", snoozed, 1'b0);
    run(4, 1'b1, 1'b0);
    run(12, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, tk());
    run(12, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tk());
    chk("dis_snz", snoozed, 1'b0);
    run(3, 1'b1, 1'b1);

    // Reset mid-burst.
    run(55, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tk());
    chk("rst_mid", ringing, 1'b0);
    run(150, 1'b1, 1'b1);

    // Randomized phase with irregular ticks and user activity.
    begin
      logic m = 1'b1, e = 1'b1;
      for (int i = 0; i < 8000; i++) begin
        if ($urandom_range(0, 299) == 0) m = ~m;
        if ($urandom_range(0, 499) == 0) e = ~e;
        if (!e && $urandom_range(0, 19) == 0) e = 1'b1;
        step($urandom_range(0, 999) == 0, e, m,
             $urandom_range(0, 149) == 0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Sequencer for the alarm indicator box and buzzer in the VGA clock display. It watches the alarm-match condition from the timekeeping logic and runs a ring/snooze/acknowledge state machine. It produces a frame-synchronous blink phase that the top level ANDs with the box generator's `alarm_on` region flag, so the red alarm box flashes only while the alarm rings. It also drives the buzzer output with the same cadence.

## Interface

Parameters:
- `FRAMES_PER_HALF`, default 30: frame ticks per blink half-period (0.5 s at 60 Hz).
- `RING_HALVES`, default 120: half-periods rung before auto-timeout (60 s).
- `SNOOZE_FRAMES`, default 18000: frame ticks spent in snooze (5 min).

Ports:
- `clk`, input, 1: system/pixel clock. One clock domain only.
- `reset`, input, 1: synchronous, active-high reset.
- `frame_tick`, input, 1: one-cycle pulse per frame (start of vertical blank), from the sync generator.
- `alarm_match`, input, 1: level, high while current time equals the programmed alarm time.
- `alarm_enable`, input, 1: level, user alarm-arm switch.
- `ack`, input, 1: debounced one-cycle pulse that stops the alarm.
- `snooze`, input, 1: debounced one-cycle pulse that snoozes the alarm.
- `box_visible`, output, 1: registered. Top level ANDs it with `alarm_on` to gate the red box pixels.
- `buzzer`, output, 1: registered buzzer drive.
- `ringing`, output, 1: registered. High in RING.
- `snoozed`, output, 1: registered. High in SNOOZE.

## Operation

- States: IDLE, RING, SNOOZE, WAIT_CLEAR. Encoding is free; all outputs are registered.
- Internal registers:
  - `frame_cnt`, width clog2(max(FRAMES_PER_HALF, SNOOZE_FRAMES)).
  - `half_cnt`, width clog2(RING_HALVES).
  - `blink_phase`, 1 bit.
- IDLE → RING when `alarm_enable & alarm_match`.
- Entering RING (from any state): `frame_cnt=0`, `half_cnt=0`, `blink_phase=1`.
- In RING, on each `frame_tick`:
  - If `frame_cnt==FRAMES_PER_HALF-1`: `frame_cnt=0`, `blink_phase` toggles, `half_cnt` increments.
  - Otherwise `frame_cnt` increments.
  - If this rollover occurs with `half_cnt==RING_HALVES-1` → WAIT_CLEAR (timeout).
- RING with `ack` → WAIT_CLEAR.
- RING with `snooze` (and no `ack`) → SNOOZE, `frame_cnt=0`.
- SNOOZE counts `frame_tick`. When `frame_cnt==SNOOZE_FRAMES-1` on a tick → RING, with fresh counters as above.
- SNOOZE with `ack` → WAIT_CLEAR.
- WAIT_CLEAR → IDLE when `alarm_match==0`. This prevents retrigger during the same matching minute.
- `alarm_enable==0` in any state → IDLE next cycle. This has priority over all other transitions except `reset`.
- Priority within one cycle: `reset` > `!alarm_enable` > `ack` > timeout > `snooze` > normal counting.
- Output values:
  - `box_visible = buzzer = (state==RING) & blink_phase`.
  - `ringing = (state==RING)`.
  - `snoozed = (state==SNOOZE)`.
  - Outside RING, `blink_phase` is held at 0.
- Re-enabling `alarm_enable` while `alarm_match` is still high re-arms and rings again. This is intentional: the user re-armed.
- `ack`/`snooze` in IDLE or WAIT_CLEAR are ignored. `snooze` in SNOOZE is ignored; the snooze timer does not restart.

## Timing

- Reset: state IDLE, counters 0, `blink_phase` 0, all outputs 0, effective the first edge with `reset` high.
- `reset` asserted mid-ring or mid-snooze aborts immediately. After release the block is in IDLE; it re-enters RING one cycle later if match and enable are still high.
- Latency:
  - Input condition sampled at edge N → state and outputs change at edge N+1.
  - `ringing` and `box_visible` rise one cycle after `alarm_match & alarm_enable` is first seen in IDLE.
- Blink toggles exactly one cycle after the `FRAMES_PER_HALF`-th `frame_tick` of each half-period.
- The first half-period of every ring burst is ON.
- Total ring duration is `RING_HALVES*FRAMES_PER_HALF` frame ticks. `ringing` falls one cycle after the final tick.
- `frame_tick` coincident with `ack`: `ack` wins and no count update occurs.
- `frame_tick` coincident with a state change: the tick is consumed only by the new state's counter reset, not counted.

## Test plan

Use `FRAMES_PER_HALF=3`, `RING_HALVES=4`, `SNOOZE_FRAMES=5`, with `frame_tick` every 10 cycles.

- Reset with `alarm_match=1`, `alarm_enable=1` → all outputs 0 during reset. `ringing=1`, `box_visible=1` one cycle after reset release.
- Ring with no user input → `box_visible` pattern 1,0,1,0 for 3 ticks each. `ringing` drops one cycle after the 12th tick. The block stays in WAIT_CLEAR until `alarm_match` falls, then IDLE with no retrigger while match is held.
- Ack after 4 ticks of ringing → `ringing`, `buzzer`, `box_visible` all 0 one cycle later. Deasserting `alarm_match` → IDLE. Reasserting `alarm_match` → rings again.
- Snooze during ring → `snoozed=1`, `box_visible=0` for 5 ticks. Then RING restarts with `box_visible=1`, `half_cnt=0`, and a full 12-tick burst follows.
- `ack` and `snooze` in the same cycle during RING → WAIT_CLEAR, `snoozed` stays 0. `alarm_enable` dropped during SNOOZE → IDLE next cycle, all outputs 0.
- `reset` pulsed mid-burst (after 5 ticks) → outputs 0 on that edge. With match still high, the new burst starts with phase ON and a full 12-tick duration.
